// File: rtl/output_delta_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : output_delta_unit_if
//  Purpose  : Bundles the output_delta_unit streams into one interface:
//             - the activation / sigmoid-prime chunk input stream
//             - the delta / end-of-sample result stream
//  Revision : 1.0  initial release
// ============================================================================
interface output_delta_unit_if #(
   parameter int WIDTH     = 16,
   parameter int M         = 2,
   parameter int CNT_WIDTH = 16
);
   // Chunk input stream from the last feedforward processor set
   logic                   in_valid;
   logic [WIDTH*M-1:0]     a_package;
   logic [WIDTH*M-1:0]     sp_package;
   logic [M-1:0]           y_bits;

   // Delta output stream and classification bookkeeping
   logic                   delta_valid;
   logic [WIDTH*M-1:0]     delta_package;
   logic                   delta_last;
   logic                   sample_done;
   logic                   correct;
   logic [CNT_WIDTH-1:0]   correct_count;

   // Producer of chunks, consumer of deltas
   modport master (
      output in_valid, a_package, sp_package, y_bits,
      input  delta_valid, delta_package, delta_last, sample_done, correct, correct_count
   );

   // The delta unit itself
   modport slave (
      input  in_valid, a_package, sp_package, y_bits,
      output delta_valid, delta_package, delta_last, sample_done, correct, correct_count
   );
endinterface
`default_nettype wire

// File: rtl/output_delta_unit.sv
`default_nettype none
// ============================================================================
//  Module   : output_delta_unit
//  Purpose  : Output-layer error stage.
//             - Computes delta = (a - y) * sigma'(s) for m neurons per cycle.
//             - Two registered stages: saturated diff, then saturated product.
//             - Tracks each sample's argmax and counts correctly classified
//               samples.
//  Revision : 1.0  initial release
// ============================================================================
module output_delta_unit #(
   parameter int FI        = 4,
   parameter int Z         = 8,
   parameter int N         = 8,
   parameter int WIDTH     = 16,
   parameter int INT_BITS  = 5,
   parameter int FRAC_BITS = 10,
   parameter int CNT_WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   output_delta_unit_if.slave bus
);

   localparam int M      = Z / FI;
   localparam int C      = N / M;
   localparam int CIDX_W = (C > 1) ? $clog2(C) : 1;
   // Product bits from the delta MSB up to the product MSB; with
   // WIDTH = 1 + INT_BITS + FRAC_BITS this equals WIDTH - FRAC_BITS + 1.
   localparam int HI_W   = INT_BITS + 2;

   localparam logic [CIDX_W-1:0]      C_LAST    = CIDX_W'(C - 1);
   localparam logic signed [WIDTH:0]  C_ONE     = (WIDTH+1)'(2 ** FRAC_BITS);
   localparam logic [WIDTH-1:0]       C_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]       C_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [CIDX_W-1:0]         r_chunk_idx;

   logic                      r_s1_valid;
   logic                      r_s1_last;
   logic signed [WIDTH-1:0]   r_s1_diff [M];
   logic signed [WIDTH-1:0]   r_s1_sp   [M];

   logic signed [WIDTH-1:0]   r_max_val;
   logic                      r_max_hit;

   logic                      r_delta_valid;
   logic [WIDTH*M-1:0]        r_delta_pkg;
   logic                      r_delta_last;
   logic                      r_sample_done;
   logic                      r_correct;
   logic [CNT_WIDTH-1:0]      r_correct_count;

   // ------------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0]   w_a        [M];
   logic signed [WIDTH-1:0]   w_sp       [M];
   logic signed [WIDTH:0]     w_diff_ext [M];
   logic signed [WIDTH-1:0]   w_diff     [M];

   logic                      w_first;
   logic signed [WIDTH-1:0]   w_max_val;
   logic                      w_max_hit;

   logic signed [2*WIDTH-1:0] w_prod     [M];
   logic [HI_W-1:0]           w_prod_hi  [M];
   logic                      w_ovf      [M];
   logic [WIDTH*M-1:0]        w_delta_pkg;
   logic                      w_end;
   logic                      w_unused;

   // Unpack the chunk and form saturated a - y in WIDTH+1 bits
   always_comb begin
      for (int k = 0; k < M; k++) begin
         w_a[k]        = bus.a_package[WIDTH*k +: WIDTH];
         w_sp[k]       = bus.sp_package[WIDTH*k +: WIDTH];
         w_diff_ext[k] = {w_a[k][WIDTH-1], w_a[k]} - (bus.y_bits[k] ? C_ONE : '0);
         if (w_diff_ext[k][WIDTH] != w_diff_ext[k][WIDTH-1]) begin
            w_diff[k] = w_diff_ext[k][WIDTH] ? C_NEG_MAX : C_POS_MAX;
         end else begin
            w_diff[k] = w_diff_ext[k][WIDTH-1:0];
         end
      end
   end

   // Running argmax over raw activations; chunk 0 restarts from its own
   // neuron 0, and only a strictly greater value replaces the max so that
   // ties keep the lower global index.
   always_comb begin
      w_first   = (r_chunk_idx == '0);
      w_max_val = w_first ? w_a[0] : r_max_val;
      w_max_hit = w_first ? bus.y_bits[0] : r_max_hit;
      for (int k = 0; k < M; k++) begin
         if (w_a[k] > w_max_val) begin
            w_max_val = w_a[k];
            w_max_hit = bus.y_bits[k];
         end
      end
   end

   // Full-precision product, rescale by FRAC_BITS and saturate on overflow
   always_comb begin
      w_delta_pkg = '0;
      w_unused    = 1'b0;
      for (int k = 0; k < M; k++) begin
         w_prod[k]    = $signed({{WIDTH{r_s1_diff[k][WIDTH-1]}}, r_s1_diff[k]}) *
                        $signed({{WIDTH{r_s1_sp[k][WIDTH-1]}},   r_s1_sp[k]});
         w_prod_hi[k] = w_prod[k][2*WIDTH-1 -: HI_W];
         w_ovf[k]     = !((&w_prod_hi[k]) || (~|w_prod_hi[k]));
         if (w_ovf[k]) begin
            w_delta_pkg[WIDTH*k +: WIDTH] = w_prod[k][2*WIDTH-1] ? C_NEG_MAX : C_POS_MAX;
         end else begin
            w_delta_pkg[WIDTH*k +: WIDTH] = w_prod[k][WIDTH+FRAC_BITS-1 : FRAC_BITS];
         end
         // Bits discarded by the truncation toward minus infinity
         w_unused = w_unused ^ (^w_prod[k][FRAC_BITS-1:0]);
      end
   end

   assign w_end = r_s1_valid & r_s1_last;

   // Chunk position within the sample, advancing only on accepted chunks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chunk_idx <= '0;
      end else if (bus.in_valid) begin
         r_chunk_idx <= (r_chunk_idx == C_LAST) ? '0 : r_chunk_idx + 1'b1;
      end
   end

   // Stage 1: register saturated differences and sigmoid-prime values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         for (int k = 0; k < M; k++) begin
            r_s1_diff[k] <= '0;
            r_s1_sp[k]   <= '0;
         end
      end else begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_last <= (r_chunk_idx == C_LAST);
            for (int k = 0; k < M; k++) begin
               r_s1_diff[k] <= w_diff[k];
               r_s1_sp[k]   <= w_sp[k];
            end
         end
      end
   end

   // Argmax tracker state, updated alongside stage 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_max_val <= '0;
         r_max_hit <= 1'b0;
      end else if (bus.in_valid) begin
         r_max_val <= w_max_val;
         r_max_hit <= w_max_hit;
      end
   end

   // Stage 2: registered deltas and end-of-sample flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_delta_valid <= 1'b0;
         r_delta_pkg   <= '0;
         r_delta_last  <= 1'b0;
         r_sample_done <= 1'b0;
         r_correct     <= 1'b0;
      end else begin
         r_delta_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_delta_pkg <= w_delta_pkg;
         end
         r_delta_last  <= w_end;
         r_sample_done <= w_end;
         r_correct     <= w_end & r_max_hit;
      end
   end

   // Saturating count of correctly classified samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_correct_count <= '0;
      end else if (r_sample_done && r_correct && (r_correct_count != '1)) begin
         r_correct_count <= r_correct_count + 1'b1;
      end
   end

   assign bus.delta_valid   = r_delta_valid;
   assign bus.delta_package = r_delta_pkg;
   assign bus.delta_last    = r_delta_last;
   assign bus.sample_done   = r_sample_done;
   assign bus.correct       = r_correct;
   assign bus.correct_count = r_correct_count;

endmodule
`default_nettype wire

// File: tb/tb_output_delta_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_delta_unit
//  Purpose  : Directed self-checking bench for output_delta_unit. Drives a
//             default instance and a 2-bit-counter instance in parallel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_output_delta_unit;

   typedef struct {
      int          due;
      logic [31:0] pkg;
      logic        last;
      logic        corr;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t dq[$];
   int   exp_cnt   = 0;
   int   exp_cnt_s = 0;
   logic inc_pend  = 1'b0;

   always #5 clk = ~clk;

   output_delta_unit_if #(.WIDTH(16), .M(2), .CNT_WIDTH(16)) bus   ();
   output_delta_unit_if #(.WIDTH(16), .M(2), .CNT_WIDTH(2))  bus_s ();

   assign bus_s.in_valid   = bus.in_valid;
   assign bus_s.a_package  = bus.a_package;
   assign bus_s.sp_package = bus.sp_package;
   assign bus_s.y_bits     = bus.y_bits;

   output_delta_unit u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   output_delta_unit #(.CNT_WIDTH(2)) u_dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // Advance one clock and compare every output against the expectation queue
   task automatic step();
      exp_t e;
      logic exp_done;
      @(posedge clk);
      #1;
      cyc++;
      if (inc_pend) begin
         exp_cnt++;
         if (exp_cnt_s != 3) exp_cnt_s++;
      end
      inc_pend = 1'b0;
      exp_done = 1'b0;
      if (dq.size() != 0 && dq[0].due == cyc) begin
         e = dq.pop_front();
         check_eq("delta_valid", {31'd0, bus.delta_valid}, 32'd1);
         check_eq("delta_package", bus.delta_package, e.pkg);
         check_eq("delta_last", {31'd0, bus.delta_last}, {31'd0, e.last});
         check_eq("sample_done", {31'd0, bus.sample_done}, {31'd0, e.last});
         if (e.last) begin
            check_eq("correct", {31'd0, bus.correct}, {31'd0, e.corr});
            inc_pend = e.corr;
            exp_done = 1'b1;
         end
      end else begin
         check_eq("delta_valid_idle", {31'd0, bus.delta_valid}, 32'd0);
         check_eq("sample_done_idle", {31'd0, bus.sample_done}, 32'd0);
      end
      check_eq("sat_sample_done", {31'd0, bus_s.sample_done}, {31'd0, exp_done});
      check_eq("correct_count", {16'd0, bus.correct_count}, exp_cnt);
      check_eq("sat_correct_count", {30'd0, bus_s.correct_count}, exp_cnt_s);
   endtask

   // Present one chunk for one cycle with its hand-computed delta
   task automatic send(input logic [31:0] a, input logic [31:0] sp, input logic [1:0] y,
                       input logic [31:0] exp_d, input logic last, input logic corr);
      bus.in_valid   = 1'b1;
      bus.a_package  = a;
      bus.sp_package = sp;
      bus.y_bits     = y;
      dq.push_back('{cyc + 2, exp_d, last, corr});
      step();
      bus.in_valid   = 1'b0;
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Activations [0.1 0.2 | 0.9 0.3 | 0.9 0.0 | 0.4 0.1], y on neuron 2, sp = 1.0
   task automatic send_sample_a(input int g0, input int g1, input int g2);
      send(32'h00CD_0066, 32'h0400_0400, 2'b00, 32'h00CD_0066, 1'b0, 1'b0); bubbles(g0);
      send(32'h0133_039A, 32'h0400_0400, 2'b01, 32'h0133_FF9A, 1'b0, 1'b0); bubbles(g1);
      send(32'h0000_039A, 32'h0400_0400, 2'b00, 32'h0000_039A, 1'b0, 1'b0); bubbles(g2);
      send(32'h0066_019A, 32'h0400_0400, 2'b00, 32'h0066_019A, 1'b1, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_dv"},    {31'd0, bus.delta_valid},   32'd0);
      check_eq({tag, "_pkg"},   bus.delta_package,          32'd0);
      check_eq({tag, "_last"},  {31'd0, bus.delta_last},    32'd0);
      check_eq({tag, "_done"},  {31'd0, bus.sample_done},   32'd0);
      check_eq({tag, "_corr"},  {31'd0, bus.correct},       32'd0);
      check_eq({tag, "_cnt"},   {16'd0, bus.correct_count}, 32'd0);
      check_eq({tag, "_scnt"},  {30'd0, bus_s.correct_count}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_now");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      dq.delete();
      exp_cnt   = 0;
      exp_cnt_s = 0;
      inc_pend  = 1'b0;
      reset     = 1'b0;
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.a_package  = '0;
      bus.sp_package = '0;
      bus.y_bits     = '0;
      @(posedge clk);
      #1;
      do_reset();
      bubbles(2);

      // Basic deltas, diff/product saturation, floor truncation; argmax = neuron 3 (y=0)
      send(32'h0300_0200, 32'h0400_0100, 2'b01, 32'h0300_FF80, 1'b0, 1'b0);
      send(32'h7FFF_8000, 32'h0800_7C00, 2'b01, 32'h7FFF_8000, 1'b0, 1'b0);
      send(32'h0001_FC00, 32'hFFFF_0180, 2'b01, 32'hFFFF_FD00, 1'b0, 1'b0);
      send(32'h0000_0000, 32'h0400_0400, 2'b00, 32'h0000_0000, 1'b1, 1'b0);
      bubbles(3);

      // Sample A (tie 2 vs 4, y on 2) then B (y on 4), back-to-back
      send_sample_a(0, 0, 0);
      send(32'h00CD_0066, 32'h0400_0400, 2'b00, 32'h00CD_0066, 1'b0, 1'b0);
      send(32'h0133_039A, 32'h0400_0400, 2'b00, 32'h0133_039A, 1'b0, 1'b0);
      send(32'h0000_039A, 32'h0400_0400, 2'b01, 32'h0000_FF9A, 1'b0, 1'b0);
      send(32'h0066_019A, 32'h0400_0400, 2'b00, 32'h0066_019A, 1'b1, 1'b0);
      // Sample C: all equal, y on neuron 1 -> neuron 0 wins the in-chunk tie
      send(32'h0100_0100, 32'h0400_0400, 2'b10, 32'hFD00_0100, 1'b0, 1'b0);
      send(32'h0100_0100, 32'h0400_0400, 2'b00, 32'h0100_0100, 1'b0, 1'b0);
      send(32'h0100_0100, 32'h0400_0400, 2'b00, 32'h0100_0100, 1'b0, 1'b0);
      send(32'h0100_0100, 32'h0400_0400, 2'b00, 32'h0100_0100, 1'b1, 1'b0);
      bubbles(3);

      // Bubble pattern 1,0,0,1,1,0,1
      send_sample_a(2, 0, 1);
      bubbles(3);
      check_eq("count_after_bubbles", {16'd0, bus.correct_count}, 32'd2);

      // Reset after chunk 2 of a sample whose chunk 0 holds a large wrong max
      send(32'h0000_7000, 32'h0400_0400, 2'b00, 32'h0000_7000, 1'b0, 1'b0);
      send(32'h0000_0000, 32'h0400_0400, 2'b00, 32'h0000_0000, 1'b0, 1'b0);
      send(32'h0000_0000, 32'h0400_0400, 2'b00, 32'h0000_0000, 1'b0, 1'b0);
      do_reset();
      send_sample_a(0, 0, 0);
      bubbles(3);
      check_eq("count_after_reset", {16'd0, bus.correct_count}, 32'd1);

      // Counter saturation: 5 correct samples, 2-bit counter goes 1,2,3,3,3
      do_reset();
      for (int s = 0; s < 5; s++) send_sample_a(0, 0, 0);
      bubbles(3);
      check_eq("count_final", {16'd0, bus.correct_count}, 32'd5);
      check_eq("sat_count_final", {30'd0, bus_s.correct_count}, 32'd3);
      check_eq("queue_drained", dq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/output_delta_unit.md
# output_delta_unit

Output-layer error stage. It sits directly downstream of the last layer's feedforward processor set and consumes its per-cycle activation and sigmoid-prime outputs (z/fi neurons per cycle). It computes the output deltas (a − y)·σ'(s) that feed the backpropagation and update processor sets. It also tracks the argmax over each sample's n output neurons and keeps a running count of correctly classified samples.

## Interface
Parameters:
- fi, 4, fan-in; with z, sets neurons per cycle m = z/fi
- z, 8, degree of parallelism; m = z/fi = 2
- n, 8, output-layer neurons; n must be a multiple of m; chunks per sample C = n/m = 4
- width, 16, signed fixed-point word width
- int_bits, 5, integer bits (width = 1 + int_bits + frac_bits)
- frac_bits, 10, fractional bits (1.0 = 2^frac_bits = 0x0400)
- cnt_width, 16, width of the correct-sample counter

Ports (clock and reset first):
- clk, input, 1, clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-high reset
- in_valid, input, 1, a_package, sp_package and y_bits carry a valid chunk this cycle
- a_package, input, width*z/fi, m activations; neuron k of the chunk is at bits [width*(k+1)-1 : width*k]
- sp_package, input, width*z/fi, m sigmoid-prime values, same packing as a_package
- y_bits, input, z/fi, ideal output bit per neuron; 1 means y = 1.0, 0 means y = 0
- delta_valid, output, 1, delta_package valid
- delta_package, output, width*z/fi, m output deltas, same packing as the inputs
- delta_last, output, 1, marks the delta chunk that ends a sample
- sample_done, output, 1, one-cycle pulse; coincides with delta_last
- correct, output, 1, valid only when sample_done = 1; 1 when the argmax neuron has y = 1
- correct_count, output, cnt_width, number of correct samples since reset; saturates at all ones

## Operation
- **Chunk counter.** chunk_idx runs 0..C−1 and advances only on in_valid. It wraps to 0 after C−1. The chunk with chunk_idx = C−1 is the last chunk of a sample. Neuron global index = chunk_idx·m + k.
- **Stage 1 (registered).**
  - diff_k = a_k − y_k, where y_k = y_bits[k] ? 2^frac_bits : 0.
  - The subtraction is computed in width+1 bits and saturated to width: positive overflow gives 0x7FFF, negative overflow gives 0x8000.
  - sp_k is registered alongside diff_k.
- **Stage 2 (registered).**
  - prod_k = diff_k·sp_k, computed as a signed 2·width-bit product.
  - delta_k = prod_k[width+frac_bits−1 : frac_bits], truncated toward −∞.
  - If the upper bits of prod_k are not a sign extension of delta_k's MSB, delta_k saturates to 0x7FFF or 0x8000 according to the sign of prod_k.
- **Argmax tracker.** Runs in stage 1 on the raw a_k values, signed comparison.
  - A strictly greater value replaces the running max. On a tie, the lower global index wins.
  - Along with the max, the tracker holds hit = y bit of the current max neuron.
  - On chunk 0 the tracker initialises from that chunk alone; the previous sample's state is ignored.
- **End of sample.** When the last chunk reaches stage 2:
  - sample_done = 1, delta_last = 1, correct = final hit.
  - correct_count increments on the same edge if correct = 1, unless it is already all ones.
- **No backpressure.** Downstream must accept every delta_valid cycle. Bubbles on in_valid are allowed anywhere, including mid-sample; all pipeline state holds during bubbles.
- **Reset values** (asynchronous, active-high):
  - chunk_idx = 0, stage valids = 0, tracker cleared.
  - delta_valid = 0, delta_package = 0, delta_last = 0, sample_done = 0, correct = 0, correct_count = 0.
- **Reset mid-sample.** The partial sample is discarded; no sample_done is produced for it. The first in_valid after reset deasserts is treated as chunk 0.

## Timing
- Latency is 2 cycles. An in_valid at edge t produces delta_valid at edge t+2 with the corresponding delta_package.
- Throughput is one chunk per cycle. A sample takes C valid cycles (4 with defaults).
- delta_valid / delta_package are registered outputs. They are held for exactly one cycle per accepted chunk; delta_package is don't-care when delta_valid = 0.
- sample_done, delta_last and correct appear in the same cycle as the last chunk's delta_valid.
- correct_count shows the updated value one cycle after sample_done.
- Back-to-back samples need no gap: chunk 0 of sample s+1 may arrive the cycle after chunk C−1 of sample s.

## Test plan
- **Basic delta.** a0 = 0x0200 (0.5), y0 = 1, sp0 = 0x0100 (0.25) → delta0 = 0xFF80 (−0.125). a1 = 0x0300, y1 = 0, sp1 = 0x0400 → delta1 = 0x0300. Both at the outputs 2 cycles after in_valid.
- **Saturation.**
  - a = 0x8000, y = 1 → diff clamps to 0x8000; with sp = 0x7C00, delta = 0x8000.
  - a = 0x7FFF, y = 0, sp = 0x0800 → delta = 0x7FFF.
- **Argmax / correct.** 4 chunks with activations [0.1, 0.2 | 0.9, 0.3 | 0.9, 0.0 | 0.4, 0.1] and y one-hot on neuron 2 → argmax = 2 (tie with neuron 4, lower index wins), correct = 1, correct_count = 1. Same data with y on neuron 4 → correct = 0 and the count is unchanged.
- **Bubbles and back-to-back.**
  - in_valid pattern 1,0,0,1,1,0,1 → sample_done exactly once, 2 cycles after the 4th valid.
  - Then 8 consecutive valids → two sample_done pulses 4 cycles apart.
- **Reset mid-sample.** Assert reset after chunk 2; then feed a full 4-chunk sample → exactly one sample_done, its argmax computed only from the new chunks, correct_count reflecting only the new sample. All outputs read 0 while reset is high.
- **Counter saturation.** Use cnt_width = 2 and run 5 correct samples → correct_count sequence 1,2,3,3,3.
